// File: rtl/output_vc_credit_tracker.sv
// Output-port credit tracker: one free-slot counter and one FREE/BUSY/DRAIN
// state machine per downstream virtual channel. A sticky flag records any
// protocol violation seen on the allocator, switch or credit interfaces.
module output_vc_credit_tracker #(
  parameter int NUM_VCS          = 2,
  parameter int CREDITS_PER_VC   = 4,
  parameter int CREDIT_CTR_WIDTH = $clog2(CREDITS_PER_VC + 1),
  parameter int VC_ID_BITS       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_arst_n,
  input  logic                                  i_alloc_valid,
  input  logic [VC_ID_BITS-1:0]                 i_alloc_vcid,
  input  logic                                  i_flit_sent,
  input  logic [VC_ID_BITS-1:0]                 i_flit_vcid,
  input  logic                                  i_flit_is_tail,
  input  logic                                  i_credit_valid,
  input  logic [VC_ID_BITS-1:0]                 i_credit_vcid,
  output logic [NUM_VCS*CREDIT_CTR_WIDTH-1:0]   o_ovc_credits_count_r,
  output logic [NUM_VCS-1:0]                    o_out_vc_free,
  output logic                                  o_credit_err
);

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } vc_state_t;

  localparam logic [CREDIT_CTR_WIDTH-1:0] LP_MAX = CREDIT_CTR_WIDTH'(CREDITS_PER_VC);

  // Out-of-range VC ids are dropped here; they never match any per-VC slice.
  logic               w_alloc_bad;
  logic               w_send_bad;
  logic               w_credit_bad;
  logic [NUM_VCS-1:0] w_vc_err;
  logic               r_credit_err;

  assign w_alloc_bad  = i_alloc_valid  && (32'(i_alloc_vcid)  >= NUM_VCS);
  assign w_send_bad   = i_flit_sent    && (32'(i_flit_vcid)   >= NUM_VCS);
  assign w_credit_bad = i_credit_valid && (32'(i_credit_vcid) >= NUM_VCS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
      localparam logic [VC_ID_BITS-1:0] LP_ID = VC_ID_BITS'(gi);

      logic                        w_alloc;
      logic                        w_send;
      logic                        w_credit;
      logic [CREDIT_CTR_WIDTH-1:0] w_cnt_next;
      vc_state_t                   w_state_next;
      logic                        w_err;
      vc_state_t                   r_state;
      logic [CREDIT_CTR_WIDTH-1:0] r_cnt;
      logic                        r_free;

      assign w_alloc  = i_alloc_valid  && (i_alloc_vcid  == LP_ID);
      assign w_send   = i_flit_sent    && (i_flit_vcid   == LP_ID);
      assign w_credit = i_credit_valid && (i_credit_vcid == LP_ID);

      // Next counter value, next state and this VC's error contribution.
      always_comb begin
        w_cnt_next   = r_cnt;
        w_state_next = r_state;
        w_err        = 1'b0;

        // A send and a credit in the same cycle cancel out.
        if (w_send && !w_credit) begin
          if (r_cnt == '0) w_err = 1'b1;
          else             w_cnt_next = r_cnt - CREDIT_CTR_WIDTH'(1);
        end else if (w_credit && !w_send) begin
          if (r_cnt == LP_MAX) w_err = 1'b1;
          else                 w_cnt_next = r_cnt + CREDIT_CTR_WIDTH'(1);
        end

        case (r_state)
          ST_FREE: begin
            // Sending on an unallocated VC is flagged but still counted.
            if (w_send)  w_err = 1'b1;
            if (w_alloc) w_state_next = ST_BUSY;
          end
          ST_BUSY: begin
            if (w_alloc) w_err = 1'b1;
            // A tail that also leaves the buffer fully credited skips DRAIN.
            if (w_send && i_flit_is_tail)
              w_state_next = (w_cnt_next == LP_MAX) ? ST_FREE : ST_DRAIN;
          end
          ST_DRAIN: begin
            if (w_alloc) w_err = 1'b1;
            if (w_cnt_next == LP_MAX) w_state_next = ST_FREE;
          end
          default: w_state_next = ST_FREE;
        endcase
      end

      // Per-VC state, counter and registered free flag.
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
          r_state <= ST_FREE;
          r_cnt   <= LP_MAX;
          r_free  <= 1'b1;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
          r_free  <= (w_state_next == ST_FREE);
        end
      end

      assign o_ovc_credits_count_r[gi*CREDIT_CTR_WIDTH +: CREDIT_CTR_WIDTH] = r_cnt;
      assign o_out_vc_free[gi] = r_free;
      assign w_vc_err[gi]      = w_err;
    end
  endgenerate

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_credit_err <= 1'b0;
    end else if ((|w_vc_err) || w_alloc_bad || w_send_bad || w_credit_bad) begin
      r_credit_err <= 1'b1;
    end
  end

  assign o_credit_err = r_credit_err;

endmodule

// File: tb/tb_output_vc_credit_tracker.sv
// Directed bench for output_vc_credit_tracker: two VCs, four credits each,
// with a 2-bit VC id so out-of-range ids can be exercised.
module tb_output_vc_credit_tracker;

  localparam int NV = 2;
  localparam int CP = 4;
  localparam int CW = 3;
  localparam int IB = 2;

  logic             clk;
  logic             arst_n;
  logic             alloc_valid;
  logic [IB-1:0]    alloc_vcid;
  logic             flit_sent;
  logic [IB-1:0]    flit_vcid;
  logic             flit_is_tail;
  logic             credit_valid;
  logic [IB-1:0]    credit_vcid;
  logic [NV*CW-1:0] cnt;
  logic [NV-1:0]    vfree;
  logic             err;

  int total = 0;
  int bad   = 0;

  output_vc_credit_tracker #(
    .NUM_VCS(NV), .CREDITS_PER_VC(CP), .CREDIT_CTR_WIDTH(CW), .VC_ID_BITS(IB)
  ) dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_alloc_valid(alloc_valid), .i_alloc_vcid(alloc_vcid),
    .i_flit_sent(flit_sent), .i_flit_vcid(flit_vcid), .i_flit_is_tail(flit_is_tail),
    .i_credit_valid(credit_valid), .i_credit_vcid(credit_vcid),
    .o_ovc_credits_count_r(cnt), .o_out_vc_free(vfree), .o_credit_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_of(input int v);
    logic [CW-1:0] c;
    c = cnt[v*CW +: CW];
    return 32'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_vcid = 0;
    flit_sent = 0; flit_vcid = 0; flit_is_tail = 0;
    credit_valid = 0; credit_vcid = 0;
  endtask

  // Present one cycle of events, let the edge take them, then clear.
  task automatic cyc(input logic av, input int aid, input logic sv, input int sid,
                     input logic tl, input logic cv, input int cid);
    alloc_valid = av; alloc_vcid = IB'(aid);
    flit_sent = sv; flit_vcid = IB'(sid); flit_is_tail = tl;
    credit_valid = cv; credit_vcid = IB'(cid);
    @(posedge clk); #1;
    idle_inputs();
    $display("step t=%0t cnt0=%0d cnt1=%0d free=%b err=%0b", $time, cnt_of(0), cnt_of(1), vfree, err);
  endtask

  task automatic do_reset();
    #2 arst_n = 0;
    #1;
    @(negedge clk);
    arst_n = 1;
    #1;
  endtask

  initial begin
    idle_inputs();
    arst_n = 0;
    #12;
    chk("rst_cnt0", cnt_of(0), 4);
    chk("rst_cnt1", cnt_of(1), 4);
    chk("rst_free", 32'(vfree), 32'h3);
    chk("rst_err", 32'(err), 0);
    arst_n = 1;

    // Alloc VC1 then send H,B,B,T with no credits.
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("alloc1_free", 32'(vfree), 32'h1);
    chk("alloc1_cnt", cnt_of(1), 4);
    cyc(0, 0, 1, 1, 0, 0, 0); chk("h_cnt1", cnt_of(1), 3);
    cyc(0, 0, 1, 1, 0, 0, 0); chk("b1_cnt1", cnt_of(1), 2);
    cyc(0, 0, 1, 1, 0, 0, 0); chk("b2_cnt1", cnt_of(1), 1);
    cyc(0, 0, 1, 1, 1, 0, 0); chk("t_cnt1", cnt_of(1), 0);
    chk("t_free", 32'(vfree), 32'h1);

    // Four credits back drain VC1 to FREE.
    cyc(0, 0, 0, 0, 0, 1, 1); chk("cr1_cnt1", cnt_of(1), 1);
    cyc(0, 0, 0, 0, 0, 1, 1); chk("cr2_cnt1", cnt_of(1), 2);
    cyc(0, 0, 0, 0, 0, 1, 1); chk("cr3_cnt1", cnt_of(1), 3);
    chk("cr3_free", 32'(vfree), 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 1); chk("cr4_cnt1", cnt_of(1), 4);
    chk("cr4_free", 32'(vfree), 32'h3);
    chk("drain_err", 32'(err), 0);

    // VC0 to count 2, VC1 to count 3, both allocated.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("multi_cnt0", cnt_of(0), 3);
    chk("multi_free", 32'(vfree), 32'h0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    chk("prep_cnt0", cnt_of(0), 2);
    chk("prep_cnt1", cnt_of(1), 3);
    cyc(0, 0, 1, 0, 0, 1, 0);
    chk("same_cnt0", cnt_of(0), 2);
    chk("same_err", 32'(err), 0);
    cyc(0, 0, 1, 0, 0, 1, 1);
    chk("split_cnt0", cnt_of(0), 1);
    chk("split_cnt1", cnt_of(1), 4);
    chk("split_err", 32'(err), 0);

    // Underflow on VC0, overflow on VC1.
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("zero_cnt0", cnt_of(0), 0);
    chk("zero_err", 32'(err), 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("uflow_cnt0", cnt_of(0), 0);
    chk("uflow_err", 32'(err), 1);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("oflow_cnt1", cnt_of(1), 4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("sticky_err", 32'(err), 1);

    // Alloc to a BUSY VC.
    do_reset();
    chk("rst2_err", 32'(err), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("busy_free", 32'(vfree), 32'h2);
    chk("busy_err0", 32'(err), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("realloc_free", 32'(vfree), 32'h2);
    chk("realloc_cnt0", cnt_of(0), 4);
    chk("realloc_err", 32'(err), 1);

    // Out-of-range VC id.
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 2);
    chk("badid_cnt0", cnt_of(0), 4);
    chk("badid_cnt1", cnt_of(1), 4);
    chk("badid_err", 32'(err), 1);
    do_reset();
    cyc(1, 3, 0, 0, 0, 0, 0);
    chk("badalloc_free", 32'(vfree), 32'h3);
    chk("badalloc_err", 32'(err), 1);

    // Reset in the middle of a drain with a send presented.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 0);
    chk("pre_cnt1", cnt_of(1), 1);
    chk("pre_free", 32'(vfree), 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("pre_err", 32'(err), 1);
    flit_sent = 1; flit_vcid = 1;
    #2 arst_n = 0;
    #1;
    chk("mrst_cnt1", cnt_of(1), 4);
    chk("mrst_free", 32'(vfree), 32'h3);
    chk("mrst_err", 32'(err), 0);
    @(posedge clk); #1;
    chk("mrst_hold_cnt1", cnt_of(1), 4);
    chk("mrst_hold_err", 32'(err), 0);
    idle_inputs();
    #2 arst_n = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_cnt1", cnt_of(1), 4);
    chk("post_free", 32'(vfree), 32'h3);

    // Alloc and tail on the same FREE VC.
    cyc(1, 0, 1, 0, 1, 0, 0);
    chk("at_free", 32'(vfree), 32'h2);
    chk("at_cnt0", cnt_of(0), 3);
    chk("at_err", 32'(err), 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("at_busy_cnt0", cnt_of(0), 4);
    chk("at_busy_free", 32'(vfree), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
